// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage HI/LO arithmetic unit.
// Fixed-latency multiply (MUL_LATENCY cycles), 32-step restoring divide plus a
// one-cycle sign fixup, MTHI/MTLO writes, flush abort and a registered busy stall.
// Optional macro MULDIV_EARLY_OUT_EN: divides whose quotient is trivially 0
// (divisor 0 or |divisor| > |dividend|) skip the iteration phase.
module ex_muldiv_unit #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] rem_q, rem_d;      // partial remainder
    logic [31:0] quo_q, quo_d;      // dividend bits shift out MSB-first, quotient bits shift in
    logic [31:0] dvsr_q, dvsr_d;    // divisor magnitude
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;        // divide by zero
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Request decode and operand conditioning
    logic        accept, is_mul, is_div, div_signed, a_neg, b_neg, early;
    logic [31:0] a_mag, b_mag;
    logic [63:0] ext_a, ext_b, product;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] sub;

    assign accept     = (state_q == IDLE) && start && !flush && (op <= OP_MTLO);
    assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed && src_a[31];
    assign b_neg      = div_signed && src_b[31];
    assign a_mag      = a_neg ? (~src_a + 32'd1) : src_a;
    assign b_mag      = b_neg ? (~src_b + 32'd1) : src_b;
    assign ext_a      = (op == OP_MULT) ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    assign ext_b      = (op == OP_MULT) ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    assign product    = ext_a * ext_b;   // low 64 bits are exact for both signednesses

`ifdef MULDIV_EARLY_OUT_EN
    assign early = (src_b == 32'd0) || (b_mag > a_mag);
`else
    assign early = 1'b0;
`endif

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    // The remainder stays below the divisor, so the 32-bit difference is exact.
    assign shifted = {rem_q, quo_q[31]};
    assign fits    = (shifted >= {1'b0, dvsr_q});
    assign sub     = shifted[31:0] - dvsr_q;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush returns any in-flight op to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_mul)      state_d = MUL_RUN;
                     else if (accept && is_div) state_d = early ? DIV_FIX : DIV_RUN;
            MUL_RUN: if (flush || cnt_q == 5'd0) state_d = IDLE;
            DIV_RUN: if (flush)                  state_d = IDLE;
                     else if (cnt_q == 5'd0)     state_d = DIV_FIX;
            DIV_FIX: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand capture, iteration, HI/LO commit
    always_comb begin
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (is_mul) begin
                    prod_d = product;
                    cnt_d  = 5'(MUL_LATENCY - 1);
                end else if (is_div) begin
                    dvsr_d  = b_mag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = (src_b == 32'd0);
                    cnt_d   = 5'd31;
                    rem_d   = early ? a_mag : 32'd0;
                    quo_d   = early ? 32'd0 : a_mag;
                end else if (op == OP_MTHI) begin
                    hi_d = src_a;
                end else begin
                    lo_d = src_a;
                end
            end
            MUL_RUN: if (!flush) begin
                if (cnt_q == 5'd0) begin
                    {hi_d, lo_d} = prod_q;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DIV_RUN: if (!flush) begin
                rem_d = fits ? sub : shifted[31:0];
                quo_d = {quo_q[30:0], fits};
                if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
            end
            DIV_FIX: if (!flush) begin
                lo_d   = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo_q + 32'd1) : quo_q);
                hi_d   = r_neg_q ? (~rem_q + 32'd1) : rem_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // Datapath and status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs straight from registers
    always_comb begin
        busy   = busy_q;
        done   = done_q;
        hi_out = hi_q;
        lo_out = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: multiply/divide results and latencies,
// divide corner cases, ignored starts, MTHI/MTLO, flush and async reset.
module tb_ex_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int TRIV_DIV_LAT = 1;
`else
    localparam int TRIV_DIV_LAT = 33;
`endif

    ex_muldiv_unit #(.MUL_LATENCY(3)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; returns at the falling edge after E0.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Count busy cycles (starting from 'pre'), then check the done pulse.
    task automatic finish_op(input string tag, input int exp_cyc, input int pre);
        int n;
        n = pre;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_done_hi"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
        @(negedge clock);
        chk({tag, "_done_fall"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi_out}, 64'd0);
        chk("rst_lo", {32'd0, lo_out}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1: MULTU 0xFFFFFFFF * 2
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        finish_op("multu", 3, 0);
        chk("multu_hi", {32'd0, hi_out}, 64'h1);
        chk("multu_lo", {32'd0, lo_out}, 64'hFFFF_FFFE);

        // 2: MULT -3 * 5
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        finish_op("mult", 3, 0);
        chk("mult_hi", {32'd0, hi_out}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo_out}, 64'hFFFF_FFF1);

        // 3: DIV -7 / 2, DIVU 100 / 0, DIV 0x80000000 / -1
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg", 33, 0);
        chk("div_neg_lo", {32'd0, lo_out}, 64'hFFFF_FFFD);
        chk("div_neg_hi", {32'd0, hi_out}, 64'hFFFF_FFFF);

        issue(3'd3, 32'd100, 32'd0);
        finish_op("divu_zero", TRIV_DIV_LAT, 0);
        chk("divu_zero_hi", {32'd0, hi_out}, 64'd100);
        chk("divu_zero_lo", {32'd0, lo_out}, 64'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 33, 0);
        chk("div_ovf_lo", {32'd0, lo_out}, 64'h8000_0000);
        chk("div_ovf_hi", {32'd0, hi_out}, 64'd0);

        // 4: DIVU 50 / 7 with a MULT start at cycle 5 that must be ignored
        issue(3'd3, 32'd50, 32'd7);
        repeat (4) @(negedge clock);
        start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        finish_op("divu_busy_start", 33, 5);
        chk("divu_busy_start_lo", {32'd0, lo_out}, 64'd7);
        chk("divu_busy_start_hi", {32'd0, hi_out}, 64'd1);
        chk("ignored_start_idle", {63'd0, busy}, 64'd0);

        // DIVU 3 / 10: trivially zero quotient
        issue(3'd3, 32'd3, 32'd10);
        finish_op("divu_small", TRIV_DIV_LAT, 0);
        chk("divu_small_lo", {32'd0, lo_out}, 64'd0);
        chk("divu_small_hi", {32'd0, hi_out}, 64'd3);

        // Op 6 is a no-op; start together with flush is ignored
        issue(3'd6, 32'hDEAD_BEEF, 32'd1);
        chk("nop_busy", {63'd0, busy}, 64'd0);
        chk("nop_hi", {32'd0, hi_out}, 64'd3);
        chk("nop_lo", {32'd0, lo_out}, 64'd0);
        @(negedge clock);
        start = 1'b1; flush = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", {63'd0, busy}, 64'd0);
        repeat (4) @(negedge clock);
        chk("start_flush_lo", {32'd0, lo_out}, 64'd0);

        // 5: MTHI/MTLO preload, then flushed DIV leaves HI/LO alone
        issue(3'd4, 32'h11, 32'd0);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        chk("mthi_done", {63'd0, done}, 64'd0);
        chk("mthi_hi", {32'd0, hi_out}, 64'h11);
        issue(3'd5, 32'h22, 32'd0);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        chk("mtlo_lo", {32'd0, lo_out}, 64'h22);

        issue(3'd2, 32'd100, 32'd3);
        chk("flush_div_busy_before", {63'd0, busy}, 64'd1);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        seen = done;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            seen = seen | done;
        end
        chk("flush_no_done", {63'd0, seen}, 64'd0);
        chk("flush_hi", {32'd0, hi_out}, 64'h11);
        chk("flush_lo", {32'd0, lo_out}, 64'h22);

        // 6: asynchronous reset during a divide
        issue(3'd2, 32'd1000, 32'd7);
        repeat (20) @(negedge clock);
        chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi_out}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo_out}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("rst_mid_stays_idle", {63'd0, busy}, 64'd0);
        chk("rst_mid_lo_after", {32'd0, lo_out}, 64'd0);

        issue(3'd1, 32'd6, 32'd7);
        finish_op("multu_post_rst", 3, 0);
        chk("multu_post_rst_lo", {32'd0, lo_out}, 64'd42);
        chk("multu_post_rst_hi", {32'd0, hi_out}, 64'd0);

        // Flush on the multiply commit edge suppresses the commit
        issue(3'd1, 32'd2, 32'd3);
        @(negedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_commit_busy", {63'd0, busy}, 64'd0);
        chk("flush_commit_done", {63'd0, done}, 64'd0);
        chk("flush_commit_lo", {32'd0, lo_out}, 64'd42);

        // Back-to-back: next op accepted in the done cycle
        issue(3'd1, 32'd5, 32'd5);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        start = 1'b1; op = 3'd3; src_a = 32'd9; src_b = 32'd4;
        @(negedge clock);
        start = 1'b0;
        chk("b2b_mul_lo", {32'd0, lo_out}, 64'd25);
        chk("b2b_div_accepted", {63'd0, busy}, 64'd1);
        finish_op("b2b_divu", 33, 0);
        chk("b2b_divu_lo", {32'd0, lo_out}, 64'd2);
        chk("b2b_divu_hi", {32'd0, hi_out}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
